// File: rtl/popcnt_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : popcnt_arb_ctrl
// Purpose  : Two-requester round-robin arbiter that feeds a STEP-bits-per-cycle
//            population-count sequencer with a valid/ready result channel.
// Revision : 1.0 - initial release
// ============================================================================
module popcnt_arb_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int RES_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_count,
    output logic             res_id,
    output logic             busy
);

    localparam int c_NSTEPS = WIDTH / STEP;
    localparam int c_SW     = $clog2(c_NSTEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [RES_W-1:0] r_acc;
    logic [c_SW-1:0]  r_step;
    logic             r_last_grant;
    logic             r_id;
    logic             r_res_valid;
    logic [RES_W-1:0] r_res_count;
    logic             r_res_id;

    logic             w_idle;
    logic             w_grant;
    logic             w_accept;
    logic [RES_W-1:0] w_chunk_cnt;
    logic [RES_W-1:0] w_acc_next;
    logic             w_last_step;

    assign w_idle = (r_state == S_IDLE);

    // Tie goes to whoever was not served last; a sole requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
    end

    assign req0_ready = w_idle && !w_grant && req0_valid;
    assign req1_ready = w_idle &&  w_grant && req1_valid;
    assign w_accept   = req0_ready || req1_ready;

    always_comb begin
        w_chunk_cnt = '0;
        for (int i = 0; i < STEP; i++) begin
            w_chunk_cnt = w_chunk_cnt + RES_W'(r_shift[i]);
        end
    end

    assign w_acc_next  = r_acc + w_chunk_cnt;
    assign w_last_step = (r_step == c_SW'(c_NSTEPS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_acc        <= '0;
            r_step       <= '0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_count  <= '0;
            r_res_id     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift      <= w_grant ? req1_data : req0_data;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_acc        <= '0;
                        r_step       <= '0;
                        r_state      <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift >> STEP;
                    r_step  <= r_step + 1'b1;
                    if (w_last_step) begin
                        r_res_count <= w_acc_next;
                        r_res_id    <= r_id;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Drain edge never overlaps an accept; IDLE is revisited first.
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_count = r_res_count;
    assign res_id    = r_res_id;
    assign busy      = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_popcnt_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcnt_arb_ctrl
// Purpose  : Directed self-checking bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_popcnt_arb_ctrl;

    localparam int WIDTH  = 32;
    localparam int STEP   = 4;
    localparam int RES_W  = 6;
    localparam int NSTEPS = WIDTH / STEP;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req0_valid, req1_valid, res_ready;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready, res_valid, res_id, busy;
    logic [RES_W-1:0] res_count;

    always #5 clk = ~clk;

    popcnt_arb_ctrl #(.WIDTH(WIDTH), .STEP(STEP), .RES_W(RES_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_count  (res_count),
        .res_id     (res_id),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Reference model: phase 0 waiting, 1 counting, 2 holding a result.
    int               m_phase = 0;
    int               m_left  = 0;
    logic             m_last  = 1'b1;
    logic [WIDTH-1:0] m_word  = '0;
    logic             m_pid   = 1'b0;
    logic             m_valid = 1'b0;
    int               m_count = 0;
    logic             m_id    = 1'b0;

    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return ~last;
        return v1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_last  = 1'b1;
            m_valid = 1'b0;
        end else if (m_phase == 0) begin
            if (req0_valid || req1_valid) begin
                m_pid   = pick(req0_valid, req1_valid, m_last);
                m_last  = m_pid;
                m_word  = m_pid ? req1_data : req0_data;
                m_left  = NSTEPS;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = 2;
                m_valid = 1'b1;
                m_count = $countones(m_word);
                m_id    = m_pid;
            end
        end else if (res_ready) begin
            m_valid = 1'b0;
            m_phase = 0;
        end
    end

    int   acc_id[$], acc_edge[$], dr_count[$], dr_id[$], rise_edge[$];
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            logic g, e0, e1;
            g  = pick(req0_valid, req1_valid, m_last);
            e0 = (m_phase == 0) && req0_valid && !g;
            e1 = (m_phase == 0) && req1_valid && g;
            chk("req0_ready", int'(req0_ready), int'(e0));
            chk("req1_ready", int'(req1_ready), int'(e1));
            chk("ready_excl", int'(req0_ready && req1_ready), 0);
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("res_valid", int'(res_valid), int'(m_valid));
            if (m_valid) begin
                chk("res_count", int'(res_count), m_count);
                chk("res_id", int'(res_id), int'(m_id));
            end
            if (req0_ready || req1_ready) begin
                acc_id.push_back(int'(req1_ready));
                acc_edge.push_back(cyc_n + 1);
            end
            if (res_valid && !prev_valid) rise_edge.push_back(cyc_n);
            if (res_valid && res_ready) begin
                dr_count.push_back(int'(res_count));
                dr_id.push_back(int'(res_id));
            end
        end
        prev_valid = res_valid;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [WIDTH-1:0] d);
        int n = 0;
        if (id == 0) begin req0_valid = 1'b1; req0_data = d; end
        else         begin req1_valid = 1'b1; req1_data = d; end
        forever begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) break;
            n++;
            if (n > 60) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        cyc();
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || res_valid) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) chk("idle_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int db, ab, n, k;
        logic [31:0] ex_cnt [4];
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data  = '0;   req1_data  = '0;
        res_ready  = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_count", int'(res_count), 0);
        chk("rst_res_id", int'(res_id), 0);
        cyc(); cyc();
        reset = 1'b0;

        // All-ones word from requester 0
        db = dr_count.size(); ab = acc_edge.size();
        send(0, 32'hFFFF_FFFF);
        wait_idle();
        chk("t1_count", dr_count[db], 32);
        chk("t1_id", dr_id[db], 0);
        chk("t1_latency", rise_edge[rise_edge.size()-1] - acc_edge[ab], 8);

        // Back-to-back words from requester 1
        db = dr_count.size(); ab = acc_edge.size();
        send(1, 32'h0000_0000);
        send(1, 32'h8000_0001);
        send(1, 32'hAAAA_AAAA);
        send(1, 32'h1234_5678);
        wait_idle();
        ex_cnt = '{0, 2, 16, 13};
        for (int i = 0; i < 4; i++) begin
            chk("t2_count", dr_count[db+i], int'(ex_cnt[i]));
            chk("t2_id", dr_id[db+i], 1);
        end
        for (int i = 0; i < 3; i++)
            chk("t2_spacing", acc_edge[ab+i+1] - acc_edge[ab+i], 10);

        // Both requesters continuously valid from reset
        pulse_reset();
        db = dr_count.size();
        req0_data = 32'h0000_000F; req1_data = 32'hF0F0_F0F0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        while (dr_count.size() < db + 4 && n < 80) begin cyc(); n++; end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        chk("t3_nresults", dr_count.size() - db, 4);
        if (dr_count.size() >= db + 4) begin
            ex_cnt = '{4, 16, 4, 16};
            for (int i = 0; i < 4; i++) begin
                chk("t3_count", dr_count[db+i], int'(ex_cnt[i]));
                chk("t3_id", dr_id[db+i], i % 2);
            end
        end

        // Backpressure in DONE; source data changes after accept
        res_ready = 1'b0;
        send(0, 32'h0000_0F0F);
        req0_data = 32'hFFFF_FFFF;
        req1_data = 32'h0000_0001; req1_valid = 1'b1;
        n = 0;
        while (!res_valid && n < 30) begin cyc(); n++; end
        chk("t4_valid_seen", int'(res_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", int'(res_valid), 1);
            chk("t4_hold_count", int'(res_count), 8);
            chk("t4_hold_id", int'(res_id), 0);
            chk("t4_ready0", int'(req0_ready), 0);
            chk("t4_ready1", int'(req1_ready), 0);
        end
        cyc();
        res_ready = 1'b1; req1_valid = 1'b0;
        wait_idle();
        chk("t4_drained", dr_count[dr_count.size()-1], 8);

        // Reset in the third COUNT cycle aborts the word
        send(1, 32'hFFFF_0000);
        cyc(); cyc();
        db = dr_count.size();
        #1 reset = 1'b1;
        #1;
        chk("t5_valid_now", int'(res_valid), 0);
        chk("t5_busy_now", int'(busy), 0);
        #1 reset = 1'b0;
        ab = acc_id.size();
        req0_data = 32'h0000_0003; req1_data = 32'h0000_00FF;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        while (acc_id.size() == ab && n < 20) begin cyc(); n++; end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        chk("t5_nresults", dr_count.size() - db, 1);
        if (acc_id.size() > ab) chk("t5_tie_grant", acc_id[ab], 0);
        if (dr_count.size() > db) begin
            chk("t5_count", dr_count[db], 2);
            chk("t5_id", dr_id[db], 0);
        end

        // Sole requester 1 is never starved
        db = dr_count.size();
        for (int i = 0; i < 3; i++) send(1, 32'h0000_0007);
        wait_idle();
        for (k = 0; k < 3; k++) begin
            chk("t6_count", dr_count[db+k], 3);
            chk("t6_id", dr_id[db+k], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
